// File: rtl/axi4_burst_led_slave.sv
// AXI4 full burst slave backed by a 2^(C_ADDR_WIDTH-2)-word register file.
// Only one burst is in flight at a time. The low bits of word 0 drive the board LEDs.
module axi4_burst_led_slave #(
  parameter int C_ID_WIDTH   = 1,
  parameter int C_DATA_WIDTH = 32,
  parameter int C_ADDR_WIDTH = 8,
  parameter int C_NUM_LEDS   = 8
) (
  input  logic                      ACLK,
  input  logic                      ARESET,
  input  logic [C_ID_WIDTH-1:0]     AWID,
  input  logic [C_ADDR_WIDTH-1:0]   AWADDR,
  input  logic [7:0]                AWLEN,
  input  logic [2:0]                AWSIZE,
  input  logic [1:0]                AWBURST,
  input  logic                      AWVALID,
  output logic                      AWREADY,
  input  logic [C_DATA_WIDTH-1:0]   WDATA,
  input  logic [C_DATA_WIDTH/8-1:0] WSTRB,
  input  logic                      WLAST,
  input  logic                      WVALID,
  output logic                      WREADY,
  output logic [C_ID_WIDTH-1:0]     BID,
  output logic [1:0]                BRESP,
  output logic                      BVALID,
  input  logic                      BREADY,
  input  logic [C_ID_WIDTH-1:0]     ARID,
  input  logic [C_ADDR_WIDTH-1:0]   ARADDR,
  input  logic [7:0]                ARLEN,
  input  logic [2:0]                ARSIZE,
  input  logic [1:0]                ARBURST,
  input  logic                      ARVALID,
  output logic                      ARREADY,
  output logic [C_ID_WIDTH-1:0]     RID,
  output logic [C_DATA_WIDTH-1:0]   RDATA,
  output logic [1:0]                RRESP,
  output logic                      RLAST,
  output logic                      RVALID,
  input  logic                      RREADY,
  output logic [C_NUM_LEDS-1:0]     LED
);
  localparam int IDX_W = C_ADDR_WIDTH - 2;
  localparam int DEPTH = 1 << IDX_W;

  typedef enum logic [2:0] {
    ST_IDLE, ST_AW_ACK, ST_WDATA, ST_WRESP, ST_AR_ACK, ST_RDATA
  } state_t;

  state_t                   state_q, state_d;
  logic                     wr_ptr_q;
  logic [C_ID_WIDTH-1:0]    id_q;
  logic [IDX_W-1:0]         idx_q;
  logic [7:0]               len_q;
  logic [1:0]               burst_q;
  logic                     err_q;
  logic [7:0]               beat_q;
  logic [C_DATA_WIDTH-1:0]  mem [DEPTH];
  logic                     rvalid_p1;
  logic [C_DATA_WIDTH-1:0]  rdata_p1;
  logic [1:0]               rresp_p1;
  logic                     rlast_p1;
  logic [C_ID_WIDTH-1:0]    rid_p1;
  logic [IDX_W-1:0]         nxt_idx;
  logic                     ar_err;
  logic                     unused_addr_bits;

  function automatic logic hdr_err(input logic [7:0] len, input logic [2:0] size,
                                   input logic [1:0] burst);
    logic wrap_ok;
    wrap_ok = (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
    return (size != 3'd2) || (burst == 2'b11) || ((burst == 2'b10) && !wrap_ok);
  endfunction

  // WRAP lengths are 2^n-1, so the low LEN bits are exactly the in-block offset mask.
  function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] idx,
                                                input logic [3:0] len, input logic [1:0] burst);
    logic [IDX_W-1:0] mask, inc;
    inc  = idx + 1'b1;
    mask = IDX_W'(len);
    case (burst)
      2'b00:   return idx;
      2'b10:   return (idx & ~mask) | (inc & mask);
      default: return inc;
    endcase
  endfunction

  assign nxt_idx          = next_idx(idx_q, len_q[3:0], burst_q);
  assign ar_err           = hdr_err(ARLEN, ARSIZE, ARBURST);
  assign unused_addr_bits = ^{AWADDR[1:0], ARADDR[1:0]};

  always_ff @(posedge ACLK) begin
    if (ARESET) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    AWREADY = 1'b0;
    WREADY  = 1'b0;
    ARREADY = 1'b0;
    BVALID  = 1'b0;
    BID     = '0;
    BRESP   = 2'b00;
    case (state_q)
      ST_IDLE: begin
        if (AWVALID && (!ARVALID || wr_ptr_q)) state_d = ST_AW_ACK;
        else if (ARVALID)                      state_d = ST_AR_ACK;
      end
      ST_AW_ACK: begin
        AWREADY = 1'b1;
        state_d = ST_WDATA;
      end
      ST_WDATA: begin
        WREADY = 1'b1;
        if (WVALID && (beat_q == len_q)) state_d = ST_WRESP;
      end
      ST_WRESP: begin
        BVALID = 1'b1;
        BID    = id_q;
        BRESP  = err_q ? 2'b10 : 2'b00;
        if (BREADY) state_d = ST_IDLE;
      end
      ST_AR_ACK: begin
        ARREADY = 1'b1;
        state_d = ST_RDATA;
      end
      ST_RDATA: begin
        if (rvalid_p1 && RREADY && (beat_q == len_q)) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      wr_ptr_q  <= 1'b1;
      err_q     <= 1'b0;
      beat_q    <= '0;
      rvalid_p1 <= 1'b0;
      rdata_p1  <= '0;
      rresp_p1  <= 2'b00;
      rlast_p1  <= 1'b0;
      rid_p1    <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (state_d != ST_IDLE) wr_ptr_q <= ~wr_ptr_q;
        end
        ST_AW_ACK: begin
          id_q    <= AWID;
          idx_q   <= AWADDR[C_ADDR_WIDTH-1:2];
          len_q   <= AWLEN;
          burst_q <= AWBURST;
          err_q   <= hdr_err(AWLEN, AWSIZE, AWBURST);
          beat_q  <= '0;
        end
        ST_WDATA: begin
          if (WVALID) begin
            if (!err_q) begin
              for (int b = 0; b < C_DATA_WIDTH/8; b++)
                if (WSTRB[b]) mem[idx_q][8*b +: 8] <= WDATA[8*b +: 8];
            end
            if (WLAST != (beat_q == len_q)) err_q <= 1'b1;
            idx_q  <= nxt_idx;
            beat_q <= beat_q + 8'd1;
          end
        end
        // p0 -> p1: header accepted, first beat read from the register file
        ST_AR_ACK: begin
          idx_q     <= ARADDR[C_ADDR_WIDTH-1:2];
          len_q     <= ARLEN;
          burst_q   <= ARBURST;
          err_q     <= ar_err;
          beat_q    <= '0;
          rvalid_p1 <= 1'b1;
          rid_p1    <= ARID;
          rlast_p1  <= (ARLEN == 8'd0);
          rresp_p1  <= ar_err ? 2'b10 : 2'b00;
          rdata_p1  <= ar_err ? '0 : mem[ARADDR[C_ADDR_WIDTH-1:2]];
        end
        ST_RDATA: begin
          if (rvalid_p1 && RREADY) begin
            if (beat_q == len_q) begin
              rvalid_p1 <= 1'b0;
              rdata_p1  <= '0;
              rresp_p1  <= 2'b00;
              rlast_p1  <= 1'b0;
              rid_p1    <= '0;
            end else begin
              idx_q    <= nxt_idx;
              beat_q   <= beat_q + 8'd1;
              rdata_p1 <= err_q ? '0 : mem[nxt_idx];
              rlast_p1 <= ((beat_q + 8'd1) == len_q);
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign RVALID = rvalid_p1;
  assign RDATA  = rdata_p1;
  assign RRESP  = rresp_p1;
  assign RLAST  = rlast_p1;
  assign RID    = rid_p1;
  assign LED    = mem[0][C_NUM_LEDS-1:0];

endmodule

// File: tb/tb_axi4_burst_led_slave.sv
// Randomized and directed burst traffic against axi4_burst_led_slave, checked
// against a word-array memory model with per-beat addresses computed arithmetically.
module tb_axi4_burst_led_slave;
  logic        ACLK = 1'b0;
  logic        ARESET;
  logic [0:0]  AWID, BID, ARID, RID;
  logic [7:0]  AWADDR, AWLEN, ARADDR, ARLEN, LED;
  logic [2:0]  AWSIZE, ARSIZE;
  logic [1:0]  AWBURST, ARBURST, BRESP, RRESP;
  logic        AWVALID, AWREADY, WLAST, WVALID, WREADY, BVALID, BREADY;
  logic        ARVALID, ARREADY, RLAST, RVALID, RREADY;
  logic [31:0] WDATA, RDATA;
  logic [3:0]  WSTRB;

  axi4_burst_led_slave #(.C_ID_WIDTH(1), .C_DATA_WIDTH(32), .C_ADDR_WIDTH(8), .C_NUM_LEDS(8)) dut (
    .ACLK(ACLK), .ARESET(ARESET),
    .AWID(AWID), .AWADDR(AWADDR), .AWLEN(AWLEN), .AWSIZE(AWSIZE), .AWBURST(AWBURST),
    .AWVALID(AWVALID), .AWREADY(AWREADY),
    .WDATA(WDATA), .WSTRB(WSTRB), .WLAST(WLAST), .WVALID(WVALID), .WREADY(WREADY),
    .BID(BID), .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
    .ARID(ARID), .ARADDR(ARADDR), .ARLEN(ARLEN), .ARSIZE(ARSIZE), .ARBURST(ARBURST),
    .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RID(RID), .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST), .RVALID(RVALID), .RREADY(RREADY),
    .LED(LED)
  );

  always #5 ACLK = ~ACLK;

  int          n_vec = 0;
  int          n_bad = 0;
  logic [31:0] ref_mem [64];
  logic [31:0] wdat [256];
  logic [3:0]  wstb [256];
  logic        wlst [256];
  int          rr_mode;
  logic [31:0] last_rdata;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int beat_word(int start, int len, int burst, int i);
    int base;
    case (burst)
      0: return start;
      2: begin
        base = (start / (len + 1)) * (len + 1);
        return base + ((start - base + i) % (len + 1));
      end
      default: return (start + i) % 64;
    endcase
  endfunction

  function automatic bit hdr_bad(int len, int size, int burst);
    return (size != 2) || (burst == 3) ||
           (burst == 2 && !(len == 1 || len == 3 || len == 7 || len == 15));
  endfunction

  task automatic step();
    @(posedge ACLK); #1;
  endtask

  task automatic model_write(int w, logic [31:0] d, logic [3:0] s);
    for (int b = 0; b < 4; b++)
      if (s[b]) ref_mem[w][8*b +: 8] = d[8*b +: 8];
  endtask

  task automatic do_reset();
    ARESET = 1'b1;
    step();
    ARESET = 1'b0;
    for (int i = 0; i < 64; i++) ref_mem[i] = '0;
  endtask

  task automatic check_idle_outputs(string tag);
    check_val({tag, "_ready"}, {AWREADY, WREADY, ARREADY}, 3'b000);
    check_val({tag, "_valid"}, {BVALID, RVALID}, 2'b00);
    check_val({tag, "_b"}, {BID, BRESP}, 3'b000);
    check_val({tag, "_r"}, {RID, RDATA, RRESP, RLAST}, 36'h0);
    check_val({tag, "_led"}, LED, 8'h00);
  endtask

  task automatic fill_random(int len);
    for (int i = 0; i <= len; i++) begin
      wdat[i] = $urandom;
      wstb[i] = 4'($urandom_range(0, 15));
      wlst[i] = (i == len) ^ ($urandom_range(0, 15) == 0);
    end
  endtask

  task automatic fill_seq(int len, logic [31:0] first);
    for (int i = 0; i <= len; i++) begin
      wdat[i] = first + 32'(i);
      wstb[i] = 4'hF;
      wlst[i] = (i == len);
    end
  endtask

  task automatic aw_start(int id, int addr, int len, int size, int burst);
    AWID = id[0:0]; AWADDR = addr[7:0]; AWLEN = len[7:0];
    AWSIZE = size[2:0]; AWBURST = burst[1:0]; AWVALID = 1'b1;
  endtask

  task automatic ar_start(int id, int addr, int len, int size, int burst);
    ARID = id[0:0]; ARADDR = addr[7:0]; ARLEN = len[7:0];
    ARSIZE = size[2:0]; ARBURST = burst[1:0]; ARVALID = 1'b1;
  endtask

  task automatic aw_wait();
    int n = 0;
    while (AWREADY !== 1'b1 && n < 50) begin step(); n++; end
    if (n >= 50) check_val("aw_timeout", AWREADY, 1'b1);
    step();
    AWVALID = 1'b0;
  endtask

  task automatic ar_wait();
    int n = 0;
    while (ARREADY !== 1'b1 && n < 50) begin step(); n++; end
    if (n >= 50) check_val("ar_timeout", ARREADY, 1'b1);
    step();
    ARVALID = 1'b0;
  endtask

  task automatic w_phase(int id, int addr, int len, int size, int burst);
    bit err;
    int n, k, start;
    err   = hdr_bad(len, size, burst);
    start = (addr >> 2) & 63;
    for (int i = 0; i <= len; i++) begin
      WVALID = 1'b0;
      if ($urandom_range(0, 3) == 0) step();
      WDATA = wdat[i]; WSTRB = wstb[i]; WLAST = wlst[i]; WVALID = 1'b1;
      n = 0;
      while (WREADY !== 1'b1 && n < 50) begin step(); n++; end
      if (n >= 50) check_val("w_timeout", WREADY, 1'b1);
      step();
      if (!err) model_write(beat_word(start, len, burst, i), wdat[i], wstb[i]);
      if (wlst[i] != (i == len)) err = 1'b1;
    end
    WVALID = 1'b0; WLAST = 1'b0;
    n = 0;
    while (BVALID !== 1'b1 && n < 50) begin step(); n++; end
    check_val("bvalid", BVALID, 1'b1);
    k = $urandom_range(0, 2);
    for (int j = 0; j < k; j++) begin step(); check_val("bvalid_hold", BVALID, 1'b1); end
    check_val("bid", BID, id);
    check_val("bresp", BRESP, err ? 2'b10 : 2'b00);
    BREADY = 1'b1;
    step();
    BREADY = 1'b0;
    check_val("bvalid_drop", BVALID, 1'b0);
    check_val("led", LED, ref_mem[0][7:0]);
  endtask

  task automatic r_phase(int id, int addr, int len, int size, int burst);
    bit err, took;
    int i, guard, cyc, w, start;
    err = hdr_bad(len, size, burst);
    start = (addr >> 2) & 63;
    i = 0; guard = 0; cyc = 0;
    check_val("rvalid_first", RVALID, 1'b1);
    while (i <= len && guard < 2000) begin
      took = 1'b0;
      if (RVALID === 1'b1) begin
        w = beat_word(start, len, burst, i);
        check_val("rdata", RDATA, err ? 32'h0 : ref_mem[w]);
        check_val("rresp", RRESP, err ? 2'b10 : 2'b00);
        check_val("rlast", RLAST, (i == len));
        check_val("rid", RID, id);
        last_rdata = RDATA;
        case (rr_mode)
          0:       RREADY = 1'($urandom_range(0, 1));
          1:       RREADY = 1'b1;
          default: RREADY = (cyc % 3 == 0);
        endcase
        took = RREADY;
      end else begin
        RREADY = 1'b0;
      end
      step();
      cyc++; guard++;
      if (took) i++;
    end
    RREADY = 1'b0;
    if (i <= len) check_val("r_timeout", i, len + 1);
    check_val("rvalid_drop", RVALID, 1'b0);
  endtask

  task automatic write_burst(int id, int addr, int len, int size, int burst);
    aw_start(id, addr, len, size, burst);
    aw_wait();
    w_phase(id, addr, len, size, burst);
  endtask

  task automatic read_burst(int id, int addr, int len, int size, int burst);
    ar_start(id, addr, len, size, burst);
    ar_wait();
    r_phase(id, addr, len, size, burst);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int len, burst, size, addr, id, n;
    int wrap_lens [4];
    wrap_lens = '{1, 3, 7, 15};
    AWID = '0; AWADDR = '0; AWLEN = '0; AWSIZE = '0; AWBURST = '0; AWVALID = 1'b0;
    ARID = '0; ARADDR = '0; ARLEN = '0; ARSIZE = '0; ARBURST = '0; ARVALID = 1'b0;
    WDATA = '0; WSTRB = '0; WLAST = 1'b0; WVALID = 1'b0; BREADY = 1'b0; RREADY = 1'b0;
    rr_mode = 1; last_rdata = '0;
    ARESET = 1'b1;
    repeat (2) @(posedge ACLK);
    #1;
    do_reset();
    check_idle_outputs("reset");

    // INCR write 1..8 and read back
    fill_seq(7, 32'd1);
    write_burst(1, 8'h00, 7, 2, 1);
    check_val("led_incr", LED, 8'h01);
    rr_mode = 1;
    read_burst(1, 8'h00, 7, 2, 1);

    // partial strobe over prior data
    wdat[0] = 32'h11223344; wstb[0] = 4'hF; wlst[0] = 1'b1;
    write_burst(0, 8'h04, 0, 2, 1);
    wdat[0] = 32'hAABBCCDD; wstb[0] = 4'b0101;
    write_burst(0, 8'h04, 0, 2, 1);
    read_burst(0, 8'h04, 0, 2, 1);
    check_val("strobe_merge", last_rdata, 32'h11BB33DD);

    // WRAP write at word 2
    wdat[0] = 32'hA1A2A3A4; wdat[1] = 32'hB1B2B3B4; wdat[2] = 32'hC1C2C3C4; wdat[3] = 32'hD1D2D3D4;
    for (int i = 0; i < 4; i++) begin wstb[i] = 4'hF; wlst[i] = (i == 3); end
    write_burst(1, 8'h08, 3, 2, 2);
    check_val("wrap_led", LED, 8'hC4);
    read_burst(1, 8'h00, 3, 2, 1);
    check_val("wrap_last", last_rdata, 32'hB1B2B3B4);

    // simultaneous AW/AR, twice: write then read
    do_reset();
    wdat[0] = 32'h5A5A0001; wstb[0] = 4'hF; wlst[0] = 1'b1;
    aw_start(1, 8'h10, 0, 2, 1);
    ar_start(0, 8'h10, 0, 2, 1);
    n = 0;
    while (AWREADY !== 1'b1 && ARREADY !== 1'b1 && n < 20) begin step(); n++; end
    check_val("arb1_grant", {AWREADY, ARREADY}, 2'b10);
    aw_wait();
    w_phase(1, 8'h10, 0, 2, 1);
    wdat[0] = 32'h5A5A0002;
    aw_start(0, 8'h14, 0, 2, 1);
    n = 0;
    while (AWREADY !== 1'b1 && ARREADY !== 1'b1 && n < 20) begin step(); n++; end
    check_val("arb2_grant", {AWREADY, ARREADY}, 2'b01);
    ar_wait();
    r_phase(0, 8'h10, 0, 2, 1);
    aw_wait();
    w_phase(0, 8'h14, 0, 2, 1);

    // RREADY pattern 1,0,0 stall
    fill_seq(3, 32'h0000C000);
    write_burst(1, 8'h40, 3, 2, 1);
    rr_mode = 2;
    read_burst(1, 8'h40, 3, 2, 1);
    rr_mode = 1;

    // illegal size: SLVERR, memory untouched
    wdat[0] = 32'hFFFFFFFF; wstb[0] = 4'hF; wlst[0] = 1'b1;
    write_burst(0, 8'h00, 0, 1, 1);
    read_burst(0, 8'h00, 0, 2, 1);

    // early WLAST on beat 2 of LEN=3
    fill_seq(3, 32'h0000E000);
    wlst[2] = 1'b1; wlst[3] = 1'b0;
    write_burst(1, 8'h20, 3, 2, 1);
    read_burst(1, 8'h20, 3, 2, 1);

    // reset pulsed during beat 3 of a write burst
    fill_seq(7, 32'h000000F0);
    aw_start(1, 8'h00, 7, 2, 1);
    aw_wait();
    for (int i = 0; i < 3; i++) begin
      WDATA = wdat[i]; WSTRB = 4'hF; WLAST = 1'b0; WVALID = 1'b1;
      step();
      model_write(i, wdat[i], 4'hF);
    end
    check_val("led_pre_rst", LED, ref_mem[0][7:0]);
    WDATA = wdat[3];
    do_reset();
    WVALID = 1'b0;
    check_idle_outputs("midrst");
    fill_seq(3, 32'h00000077);
    write_burst(0, 8'h00, 3, 2, 1);
    read_burst(0, 8'h00, 3, 2, 1);

    // randomized traffic
    for (int t = 0; t < 40; t++) begin
      len   = $urandom_range(0, 15);
      burst = $urandom_range(0, 3);
      size  = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 3) : 2;
      addr  = $urandom_range(0, 255);
      id    = $urandom_range(0, 1);
      if (burst == 2 && $urandom_range(0, 3) != 0) len = wrap_lens[$urandom_range(0, 3)];
      if ($urandom_range(0, 1) == 1) begin
        fill_random(len);
        write_burst(id, addr, len, size, burst);
      end else begin
        rr_mode = $urandom_range(0, 2);
        read_burst(id, addr, len, size, burst);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
